// File: rtl/hyperbus_pkg.sv
// Shared definitions for the Hyperbus user-side blocks: FSM encodings,
// command direction codes and the default watchdog length.
package hyperbus_pkg;

  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_ISSUE = 4'b0010;
  localparam logic [3:0] ST_WAIT  = 4'b0100;
  localparam logic [3:0] ST_DONE  = 4'b1000;

  localparam logic CMD_READ  = 1'b1;
  localparam logic CMD_WRITE = 1'b0;

  localparam int DEFAULT_TIMEOUT = 1023;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hyperbus_arbiter_if.sv
// Requester-side and FIFO-side bundle of the Hyperbus arbiter.
interface hyperbus_arbiter_if
  import hyperbus_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int GW = idx_width(NREQ);

  // Requesters hold req_rrq/req_wrq high until the cycle req_ack[i] is high and
  // drop them on the edge that ends that cycle; the arbiter issues one FIFO command
  // (single-cycle fifo_rrq/fifo_wrq) and treats one fifo_rx_valid pulse as its completion.
  logic [NREQ-1:0]            req_rrq;
  logic [NREQ-1:0]            req_wrq;
  logic [NREQ*ADDR_WIDTH-1:0] req_adr;
  logic [NREQ*DATA_WIDTH-1:0] req_wdat;
  logic [NREQ-1:0]            req_ack;
  logic [NREQ-1:0]            req_err;
  logic [DATA_WIDTH-1:0]      req_rdat;
  logic [GW-1:0]              grant;
  logic                       busy;
  logic                       stray;
  logic                       fifo_rrq;
  logic                       fifo_wrq;
  logic [ADDR_WIDTH-1:0]      fifo_adr;
  logic [DATA_WIDTH-1:0]      fifo_wdat;
  logic [DATA_WIDTH-1:0]      fifo_rx_dat;
  logic                       fifo_rx_valid;

  modport slave (
    input  req_rrq, req_wrq, req_adr, req_wdat, fifo_rx_dat, fifo_rx_valid,
    output req_ack, req_err, req_rdat, grant, busy, stray,
           fifo_rrq, fifo_wrq, fifo_adr, fifo_wdat
  );

  modport master (
    output req_rrq, req_wrq, req_adr, req_wdat, fifo_rx_dat, fifo_rx_valid,
    input  req_ack, req_err, req_rdat, grant, busy, stray,
           fifo_rrq, fifo_wrq, fifo_adr, fifo_wdat
  );

endinterface

// File: rtl/hyperbus_rr_pick.sv
// Combinational round-robin picker: the first pending index after ptr wins,
// scanning upward with wrap-around.
module hyperbus_rr_pick
  import hyperbus_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] pend_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [IW-1:0]   idx_o,
  output logic            valid_o
);

  logic [IW:0] sum;

  // Walk from the farthest candidate to the nearest so the nearest pending one is kept.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    sum     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      sum = {1'b0, ptr_i} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      if (pend_i[sum[IW-1:0]]) begin
        idx_o   = sum[IW-1:0];
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hyperbus_arbiter.sv
// Round-robin arbiter sharing the hyperbus_fifo command port among NREQ requesters,
// with one outstanding single-word command and a completion watchdog.
module hyperbus_arbiter
  import hyperbus_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  hyperbus_arbiter_if.slave  bus,
  output logic [3:0]         state_o
);

  localparam int IW = idx_width(NREQ);
  localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  logic [3:0]            state_q, state_d;
  logic [IW-1:0]         ptr_q, grant_q;
  logic                  dir_q;
  logic [CW-1:0]         cnt_q;
  logic [NREQ-1:0]       ack_q, err_q;
  logic [DATA_WIDTH-1:0] rdat_q, wdat_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic                  busy_q, stray_q, fifo_rrq_q, fifo_wrq_q;

  logic [NREQ-1:0] pend;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid, pick_dir, timeout_hit;

  assign pend = bus.req_rrq | bus.req_wrq;

  hyperbus_rr_pick #(.NREQ(NREQ)) u_pick (
    .pend_i  (pend),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // A requester raising both lines gets its read served first.
  assign pick_dir    = bus.req_rrq[pick_idx] ? CMD_READ : CMD_WRITE;
  assign timeout_hit = (TIMEOUT != 0) && (({1'b0, cnt_q} + (CW+1)'(1)) == (CW+1)'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pick_valid) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (bus.fifo_rx_valid || timeout_hit) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= IW'(NREQ - 1);
      grant_q    <= '0;
      dir_q      <= CMD_WRITE;
      cnt_q      <= '0;
      ack_q      <= '0;
      err_q      <= '0;
      rdat_q     <= '0;
      adr_q      <= '0;
      wdat_q     <= '0;
      busy_q     <= 1'b0;
      stray_q    <= 1'b0;
      fifo_rrq_q <= 1'b0;
      fifo_wrq_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= (state_d != ST_IDLE);
      ack_q      <= '0;
      err_q      <= '0;
      fifo_rrq_q <= 1'b0;
      fifo_wrq_q <= 1'b0;
      if (bus.fifo_rx_valid && (state_q != ST_WAIT)) stray_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_q    <= pick_idx;
            dir_q      <= pick_dir;
            adr_q      <= bus.req_adr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            wdat_q     <= bus.req_wdat[pick_idx*DATA_WIDTH +: DATA_WIDTH];
            fifo_rrq_q <= (pick_dir == CMD_READ);
            fifo_wrq_q <= (pick_dir == CMD_WRITE);
          end
        end
        ST_ISSUE: cnt_q <= '0;
        ST_WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          if (bus.fifo_rx_valid) begin
            if (dir_q == CMD_READ) rdat_q <= bus.fifo_rx_dat;
            ack_q[grant_q] <= 1'b1;
          end else if (timeout_hit) begin
            ack_q[grant_q] <= 1'b1;
            err_q[grant_q] <= 1'b1;
          end
        end
        ST_DONE: ptr_q <= grant_q;
        default: ;
      endcase
    end
  end

  assign bus.req_ack   = ack_q;
  assign bus.req_err   = err_q;
  assign bus.req_rdat  = rdat_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
  assign bus.stray     = stray_q;
  assign bus.fifo_rrq  = fifo_rrq_q;
  assign bus.fifo_wrq  = fifo_wrq_q;
  assign bus.fifo_adr  = adr_q;
  assign bus.fifo_wdat = wdat_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_hyperbus_arbiter.sv
// Self-checking bench for hyperbus_arbiter: directed scenarios followed by random
// request traffic, checked against a transaction-level round-robin model.
module tb_hyperbus_arbiter;
  import hyperbus_pkg::*;

  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TO   = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] state;

  always #5 clk = ~clk;

  hyperbus_arbiter_if #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  hyperbus_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state)
  );

  int checks = 0;
  int errors = 0;

  logic [NREQ-1:0] rrq_v, wrq_v;
  logic [AW-1:0]   adr_a [NREQ];
  logic [DW-1:0]   wdat_a[NREQ];
  int              last_m;
  logic [DW-1:0]   rdat_m;
  logic            stray_m;
  logic [DW-1:0]   exp_q[$];
  int              rd_pulses = 0;
  int              wr_pulses = 0;

  always @(posedge clk) begin
    if (bus.fifo_rrq) rd_pulses++;
    if (bus.fifo_wrq) wr_pulses++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.req_rrq = rrq_v;
    bus.req_wrq = wrq_v;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_adr[i*AW +: AW]  = adr_a[i];
      bus.req_wdat[i*DW +: DW] = wdat_a[i];
    end
  endtask

  // The next winner is the first pending requester after the last one served.
  function automatic int rr_expect(input logic [NREQ-1:0] p, input int last);
    for (int d = 1; d <= NREQ; d++)
      if (p[(last + d) % NREQ]) return (last + d) % NREQ;
    return -1;
  endfunction

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_grant"}, bus.grant, 0);
    chk({pfx, "_ack"},   bus.req_ack, 0);
    chk({pfx, "_err"},   bus.req_err, 0);
    chk({pfx, "_rdat"},  bus.req_rdat, 0);
    chk({pfx, "_busy"},  bus.busy, 0);
    chk({pfx, "_stray"}, bus.stray, 0);
    chk({pfx, "_rrq"},   bus.fifo_rrq, 0);
    chk({pfx, "_wrq"},   bus.fifo_wrq, 0);
    chk({pfx, "_adr"},   bus.fifo_adr, 0);
    chk({pfx, "_wdat"},  bus.fifo_wdat, 0);
    chk({pfx, "_state"}, state, ST_IDLE);
  endtask

  task automatic model_reset();
    last_m  = NREQ - 1;
    rdat_m  = '0;
    stray_m = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.fifo_rx_valid = 1'b0;
    rrq_v = '0;
    wrq_v = '0;
    drive();
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;
    model_reset();
  endtask

  // Serves one transaction from an IDLE negedge; returns at the IDLE negedge after DONE.
  task automatic run_one(input int lat, input bit respond, input logic [DW-1:0] rdata,
                         input bit keep, output int g);
    int            eg, n;
    bit            rd;
    logic [DW-1:0] exp_rd;
    eg = rr_expect(rrq_v | wrq_v, last_m);
    rd = rrq_v[eg];
    @(negedge clk);
    chk("issue_rrq",   bus.fifo_rrq, rd);
    chk("issue_wrq",   bus.fifo_wrq, !rd);
    chk("issue_grant", bus.grant, eg);
    chk("issue_adr",   bus.fifo_adr, adr_a[eg]);
    chk("issue_wdat",  bus.fifo_wdat, wdat_a[eg]);
    chk("issue_busy",  bus.busy, 1);
    if (respond && rd) exp_q.push_back(rdata);
    n = respond ? lat : TO;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      chk("wait_ack", bus.req_ack, 0);
      chk("wait_cmd", {bus.fifo_rrq, bus.fifo_wrq}, 0);
    end
    if (respond) begin
      bus.fifo_rx_valid = 1'b1;
      bus.fifo_rx_dat   = rdata;
    end
    @(negedge clk);
    bus.fifo_rx_valid = 1'b0;
    bus.fifo_rx_dat   = $urandom;
    exp_rd = rdat_m;
    if (respond && rd) exp_rd = exp_q.pop_front();
    chk("done_ack",  bus.req_ack, 64'(1) << eg);
    chk("done_err",  bus.req_err, respond ? 64'(0) : (64'(1) << eg));
    chk("done_rdat", bus.req_rdat, exp_rd);
    chk("done_busy", bus.busy, 1);
    rdat_m = exp_rd;
    if (!keep) begin
      if (rd) rrq_v[eg] = 1'b0;
      else    wrq_v[eg] = 1'b0;
    end
    drive();
    last_m = eg;
    g = eg;
    @(negedge clk);
    chk("idle_busy",  bus.busy, 0);
    chk("idle_ack",   bus.req_ack, 0);
    chk("idle_stray", bus.stray, stray_m);
  endtask

  initial begin
    int g, rd0, wr0, lat;
    bit respond;
    bus.fifo_rx_valid = 1'b0;
    bus.fifo_rx_dat   = '0;
    for (int i = 0; i < NREQ; i++) begin
      adr_a[i]  = '0;
      wdat_a[i] = '0;
    end
    rrq_v = '0;
    wrq_v = '0;
    drive();
    model_reset();
    @(negedge clk);
    do_reset();

    // Single read from requester 2, completion 5 cycles after issue.
    rrq_v[2] = 1'b1; adr_a[2] = 32'h0000_0100; wdat_a[2] = 32'h5555_AAAA;
    drive();
    run_one(5, 1'b1, 32'hCAFE_F00D, 1'b0, g);
    chk("single_rdat_hold", bus.req_rdat, 32'hCAFE_F00D);

    // All four write at once: round-robin order from a fresh reset.
    do_reset();
    rd0 = rd_pulses; wr0 = wr_pulses;
    for (int i = 0; i < NREQ; i++) begin
      wrq_v[i] = 1'b1; adr_a[i] = 32'(4 * i); wdat_a[i] = 32'(8'h11 * (i + 1));
    end
    drive();
    for (int t = 0; t < NREQ; t++) run_one(1 + t, 1'b1, $urandom, 1'b0, g);
    chk("rr_wr_pulses", wr_pulses - wr0, 4);
    chk("rr_rd_pulses", rd_pulses - rd0, 0);
    chk("rr_rdat_kept", bus.req_rdat, 0);

    // Requesters 0 and 3 keep requesting continuously.
    rrq_v[0] = 1'b1; adr_a[0] = 32'h40; wrq_v[3] = 1'b1; adr_a[3] = 32'h4C; wdat_a[3] = 32'hD00D;
    drive();
    for (int t = 0; t < 6; t++) run_one(2, 1'b1, $urandom, 1'b1, g);
    rrq_v = '0; wrq_v = '0;
    drive();

    // Requester 1 read never completes; a late completion then marks stray.
    rrq_v[1] = 1'b1; adr_a[1] = 32'h0000_2000;
    drive();
    run_one(0, 1'b0, '0, 1'b0, g);
    repeat (2) @(negedge clk);
    bus.fifo_rx_valid = 1'b1;
    bus.fifo_rx_dat   = 32'hBAD0_BAD0;
    @(negedge clk);
    bus.fifo_rx_valid = 1'b0;
    stray_m = 1'b1;
    chk("late_stray", bus.stray, 1);
    chk("late_ack",   bus.req_ack, 0);
    chk("late_rdat",  bus.req_rdat, rdat_m);
    chk("late_busy",  bus.busy, 0);

    // Requester 0 raises both directions: read first, then the held write.
    rrq_v[0] = 1'b1; wrq_v[0] = 1'b1; adr_a[0] = 32'h80; wdat_a[0] = 32'h1234_5678;
    drive();
    run_one(3, 1'b1, 32'h0BAD_CAFE, 1'b0, g);
    run_one(16, 1'b1, 32'hFFFF_0000, 1'b0, g);

    // Reset during WAIT abandons the command; requester 0 wins next.
    rrq_v[1] = 1'b1; adr_a[1] = 32'h300;
    drive();
    @(negedge clk);
    chk("rstw_issue", bus.fifo_rrq, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    rrq_v = '0; wrq_v[0] = 1'b1; wrq_v[3] = 1'b1;
    adr_a[0] = 32'h10; adr_a[3] = 32'h1C;
    drive();
    @(negedge clk);
    check_all_zero("rstw");
    rst_n = 1'b1;
    model_reset();
    run_one(4, 1'b1, $urandom, 1'b0, g);
    run_one(4, 1'b1, $urandom, 1'b0, g);

    // Random traffic with random latency and occasional lost completions.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(rrq_v[i] | wrq_v[i]) && $urandom_range(0, 2) == 0) begin
          adr_a[i]  = $urandom;
          wdat_a[i] = $urandom;
          case ($urandom_range(0, 3))
            0, 1:    rrq_v[i] = 1'b1;
            2:       wrq_v[i] = 1'b1;
            default: begin rrq_v[i] = 1'b1; wrq_v[i] = 1'b1; end
          endcase
        end
      end
      if ((rrq_v | wrq_v) == '0) begin
        g = $urandom_range(0, NREQ - 1);
        wrq_v[g] = 1'b1; adr_a[g] = $urandom; wdat_a[g] = $urandom;
      end
      drive();
      lat     = $urandom_range(1, TO);
      respond = ($urandom_range(0, 7) != 0);
      run_one(lat, respond, $urandom, 1'b0, g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hyperbus_arbiter.md
# hyperbus_arbiter

Round-robin arbiter that shares the user-side command port of `hyperbus_fifo` among `NREQ` requesters, such as a CPU bus bridge, DMA engines and a debug port. It accepts level-held read and write requests and issues exactly one single-word command into the FIFO front end. It holds that command as the only outstanding transaction until the FIFO's `rx_valid` completion arrives, then returns read data and a one-cycle ack to the granted requester. A watchdog terminates transactions whose completion never arrives.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `ADDR_WIDTH`, 32: address width, matching FIFO `adr_i`.
- `DATA_WIDTH`, 32: data width, matching FIFO `tx_dat_i` and `rx_dat_o`.
- `TIMEOUT`, 1023: WAIT-state cycles before the transaction is aborted; 0 disables the watchdog.
- `clk` in 1: single clock, the FIFO user clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_rrq` in NREQ: per-requester read request, held high until ack.
- `req_wrq` in NREQ: per-requester write request, held high until ack.
- `req_adr` in NREQ*ADDR_WIDTH: packed addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdat` in NREQ*DATA_WIDTH: packed write data, packed the same way as `req_adr`.
- `req_ack` out NREQ: one-hot, one-cycle completion pulse.
- `req_err` out NREQ: one-cycle timeout flag, asserted together with `req_ack`.
- `req_rdat` out DATA_WIDTH: read data, shared by all requesters; valid while `req_ack` is high for a read.
- `grant` out max(1,$clog2(NREQ)): index of the current or last granted requester.
- `busy` out 1: high in every state except IDLE.
- `stray` out 1: sticky flag, set when `fifo_rx_valid` arrives outside WAIT; cleared only by reset.
- `fifo_rrq` out 1: drives FIFO `rrq`.
- `fifo_wrq` out 1: drives FIFO `wrq`.
- `fifo_adr` out ADDR_WIDTH: drives FIFO `adr_i`.
- `fifo_wdat` out DATA_WIDTH: drives FIFO `tx_dat_i`.
- `fifo_rx_dat` in DATA_WIDTH: from FIFO `rx_dat_o`.
- `fifo_rx_valid` in 1: from FIFO `rx_valid`; a single pulse signals read data or write ack.

## Operation
- Four states, one-hot: IDLE, ISSUE, WAIT, DONE.
- IDLE
  - Requester i is pending when `req_rrq[i]|req_wrq[i]` is high.
  - Scan starts at (ptr+1) mod NREQ and increments with wrap; the first pending index wins.
  - On a win, latch the index, address, data and direction, then go to ISSUE.
  - If a requester asserts both `req_rrq` and `req_wrq`, the read wins.
- ISSUE
  - Drive `fifo_rrq` or `fifo_wrq` high for exactly this one cycle; `fifo_adr` and `fifo_wdat` carry the latched values.
  - Clear the watchdog counter, then go to WAIT.
- WAIT
  - The counter increments each cycle.
  - On `fifo_rx_valid`: for a read, load `req_rdat <= fifo_rx_dat` (writes leave `req_rdat` unchanged); go to DONE.
  - Timeout: TIMEOUT != 0 and the counter reaches TIMEOUT without `fifo_rx_valid`. Go to DONE with the error flagged and `req_rdat` unchanged.
  - Counter width is $clog2(TIMEOUT+1), minimum 1.
- DONE
  - `req_ack[grant]` is high for this one cycle; `req_err[grant]` is also high if a timeout occurred.
  - ptr <= grant; this update also happens on error.
  - Go to IDLE unconditionally.
- Requester rule: drop the request on the clock edge that ends the ack cycle. A request still high in the following IDLE cycle is treated as a new transaction.
- A `fifo_rx_valid` seen in IDLE, ISSUE or DONE is discarded and sets `stray`. This covers a late completion after a timeout, or a completion after reset mid-transaction.
- Requests do not interact with the FIFO during WAIT; exactly one command is outstanding at any time.

## Timing
- Reset (`rst_n` low at an edge, from any state):
  - State returns to IDLE and ptr is set to NREQ-1, so requester 0 has first priority.
  - `grant`, `req_ack`, `req_err`, `req_rdat`, `busy`, `stray`, `fifo_rrq`, `fifo_wrq`, `fifo_adr` and `fifo_wdat` are all 0.
  - An in-flight FIFO command is abandoned.
- All outputs are registered.
- Cycle numbering, from a request sampled in IDLE at edge 0:
  - Cycle 1: ISSUE, `fifo_rrq` or `fifo_wrq` high.
  - Cycle 2 onward: WAIT.
  - `fifo_rx_valid` sampled high in WAIT cycle k: DONE and ack in cycle k+1, IDLE in cycle k+2.
- Back-to-back minimum is 4 cycles plus the FIFO round trip.
- Timeout: DONE occurs TIMEOUT+1 cycles after the ISSUE cycle.

## Structure
- `hyperbus_pkg` holds:
  - the state encodings;
  - `CMD_READ`=1 and `CMD_WRITE`=0;
  - the default TIMEOUT.
- Sub-module `hyperbus_rr_pick` is purely combinational: pending vector and ptr in, winner index and valid out. It is reused by any later multi-port Hyperbus block.

## Test plan
- Single read: after reset, requester 2 reads 0x0000_0100, and `fifo_rx_valid` arrives 5 cycles after issue with data 0xCAFE_F00D.
  - `fifo_rrq` pulses once with `fifo_adr`=0x100.
  - `req_ack`=4'b0100 for one cycle with `req_rdat`=0xCAFE_F00D.
  - `req_err`=0.
- Round-robin: all 4 requesters write at once, with data 0x11/0x22/0x33/0x44 and addresses 0x0..0xC.
  - Grants go 0,1,2,3.
  - `fifo_wdat` follows the same order.
  - Exactly 4 FIFO write pulses are seen.
- Fairness: requesters 0 and 3 re-request continuously. Grants alternate 0,3,0,3, and no requester waits more than one transaction.
- Timeout: with TIMEOUT=16, requester 1 reads and no completion is returned.
  - `req_ack[1]` and `req_err[1]` are high in cycle 17 after ISSUE.
  - `req_rdat` is unchanged.
  - A completion injected 3 cycles later sets `stray`=1.
- Simultaneous read and write: requester 0 asserts both.
  - A read is issued (`fifo_rrq`=1, `fifo_wrq`=0).
  - Because `req_wrq` is still high, a write follows as the next transaction.
- Reset mid-WAIT: `rst_n` goes low for 1 cycle during WAIT.
  - All outputs are 0 next cycle and `busy`=0.
  - The next grant goes to requester 0, even though requester 3 also requests.
